iahb_master: RTL and testbench

- Instruction-side AHB-Lite master. Sits directly downstream of the instruction memory controller.
- Converts its IAHB request (IAHB_access level plus IAHB_addr) into single NONSEQ 32-bit read transfers on the instruction AHB bus.
- Returns the fetched word as IAHB_read_data with a one-cycle IAHB_read_data_valid pulse.
- Supports one outstanding transfer, wait states, error responses and a fetch flush (branch redirect).

---
 rtl/iahb_master_if.sv | 32 +++
 rtl/iahb_master.sv | 172 +++++++++++++++++
 tb/tb_iahb_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/iahb_master_if.sv
// AHB-Lite instruction bus bundle between the instruction-side master and the
// bus fabric. The master modport drives the address/control signals and
// receives read data and the response.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface iahb_master_if;
    logic [`ADDR_WIDTH-1:0]  HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [3:0]              HPROT;
    logic [`INSTR_WIDTH-1:0] HRDATA;
    logic                    HREADY;
    logic                    HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/iahb_master.sv
// Instruction-side AHB-Lite master.
// Turns a fetch request (IAHB_access + IAHB_addr) into a single NONSEQ
// 32-bit read. One transfer is outstanding at a time. fetch_flush drops the
// result of an in-flight fetch without withdrawing the bus transfer.
// Optional feature macro: IAHB_ERR_REPORT_EN adds IAHB_bus_error and
// IAHB_err_addr. Without it, an error response looks like fetching 32'h0.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module iahb_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0010
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rstn,
    input  logic                    IAHB_access,
    input  logic [`ADDR_WIDTH-1:0]  IAHB_addr,
    input  logic                    fetch_flush,
    output logic [`INSTR_WIDTH-1:0] IAHB_read_data,
    output logic                    IAHB_read_data_valid,
    output logic                    IAHB_busy,
`ifdef IAHB_ERR_REPORT_EN
    output logic                    IAHB_bus_error,
    output logic [`ADDR_WIDTH-1:0]  IAHB_err_addr,
`endif
    iahb_master_if.master           ahb
);

    localparam int AW = `ADDR_WIDTH;
    localparam int IW = `INSTR_WIDTH;

    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
    localparam logic [AW-1:0] WORD_MASK     = {{(AW-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_r;
    logic            drop_r;
    logic            valid_r;
    logic            busy_r;
    logic [1:0]      htrans_r;
    logic [IW-1:0]   rdata_r;
`ifdef IAHB_ERR_REPORT_EN
    logic            bus_err_r;
    logic [AW-1:0]   err_addr_r;
`endif

    // Transfer sequencer: address phase, data phase, two-cycle error
    // response, then a one-cycle DONE turnaround where the result is
    // presented. drop_r remembers a flush seen while the transfer was on
    // the bus so its result is silently discarded.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state    <= S_IDLE;
            addr_r   <= '0;
            drop_r   <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            htrans_r <= HTRANS_IDLE;
            rdata_r  <= '0;
`ifdef IAHB_ERR_REPORT_EN
            bus_err_r  <= 1'b0;
            err_addr_r <= '0;
`endif
        end else begin
            valid_r <= 1'b0;
`ifdef IAHB_ERR_REPORT_EN
            bus_err_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (IAHB_access && !fetch_flush) begin
                        addr_r   <= IAHB_addr;
                        htrans_r <= HTRANS_NONSEQ;
                        busy_r   <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (fetch_flush) begin
                        drop_r <= 1'b1;
                    end
                    if (ahb.HREADY) begin
                        htrans_r <= HTRANS_IDLE;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (fetch_flush) begin
                        drop_r <= 1'b1;
                    end
                    if (ahb.HRESP) begin
`ifdef IAHB_ERR_REPORT_EN
                        err_addr_r <= addr_r;
`endif
                        if (ahb.HREADY) begin
                            rdata_r <= '0;
                            valid_r <= !(drop_r || fetch_flush);
`ifdef IAHB_ERR_REPORT_EN
                            bus_err_r <= !(drop_r || fetch_flush);
`endif
                            state   <= S_DONE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (ahb.HREADY) begin
                        rdata_r <= ahb.HRDATA;
                        valid_r <= !(drop_r || fetch_flush);
                        state   <= S_DONE;
                    end
                end
                S_ERR: begin
                    if (fetch_flush) begin
                        drop_r <= 1'b1;
                    end
                    if (ahb.HREADY) begin
                        rdata_r <= '0;
                        valid_r <= !(drop_r || fetch_flush);
`ifdef IAHB_ERR_REPORT_EN
                        bus_err_r <= !(drop_r || fetch_flush);
`endif
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    drop_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_r   <= 1'b0;
                    drop_r   <= 1'b0;
                    htrans_r <= HTRANS_IDLE;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving during DONE must still kill the pulse in that same
    // cycle, so the registered pulse is gated by the live flush input.
    assign IAHB_read_data_valid = valid_r & ~fetch_flush;
    assign IAHB_read_data       = rdata_r;
    assign IAHB_busy            = busy_r;

`ifdef IAHB_ERR_REPORT_EN
    assign IAHB_bus_error = bus_err_r & ~fetch_flush;
    assign IAHB_err_addr  = err_addr_r;
`endif

    // addr_r only changes on acceptance, so HADDR is stable for the whole
    // address phase; the byte-offset bits never reach the bus.
    assign ahb.HADDR  = addr_r & WORD_MASK;
    assign ahb.HTRANS = htrans_r;
    assign ahb.HWRITE = 1'b0;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = HPROT_VAL;

endmodule

// File: tb/tb_iahb_master.sv
// Self-checking bench for iahb_master. A cycle-stepped AHB slave driver
// plays out each planned fetch (wait states, error, flush point) and a
// transaction-level model decides whether a valid pulse is due and what
// data it carries.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_iahb_master;

    logic                    cpu_clk;
    logic                    cpu_rstn;
    logic                    IAHB_access;
    logic [`ADDR_WIDTH-1:0]  IAHB_addr;
    logic                    fetch_flush;
    logic [`INSTR_WIDTH-1:0] IAHB_read_data;
    logic                    IAHB_read_data_valid;
    logic                    IAHB_busy;
`ifdef IAHB_ERR_REPORT_EN
    logic                    IAHB_bus_error;
    logic [`ADDR_WIDTH-1:0]  IAHB_err_addr;
`endif

    int checks = 0;
    int errors = 0;

    iahb_master_if bus ();

    iahb_master #(.HPROT_VAL(4'b0010)) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rstn             (cpu_rstn),
        .IAHB_access          (IAHB_access),
        .IAHB_addr            (IAHB_addr),
        .fetch_flush          (fetch_flush),
        .IAHB_read_data       (IAHB_read_data),
        .IAHB_read_data_valid (IAHB_read_data_valid),
        .IAHB_busy            (IAHB_busy),
`ifdef IAHB_ERR_REPORT_EN
        .IAHB_bus_error       (IAHB_bus_error),
        .IAHB_err_addr        (IAHB_err_addr),
`endif
        .ahb                  (bus)
    );

    // Free-running clock
    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays one fetch. Entered at a negedge with the DUT idle in the coming
    // cycle; returns at the negedge of the idle cycle after DONE.
    // flush_idx counts bus-occupied cycles (address, data, error) from 0;
    // a negative or out-of-range value means no flush on the bus.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d,
                           input int wa, input int wd, input bit err,
                           input int flush_idx, input bit flush_done,
                           input bit hold_next, input logic [31:0] next_a);
        int          n_data;
        int          n_busy;
        int          bc;
        bit          exp_valid;
        logic [31:0] exp_data;
        n_data    = err ? wd + 2 : wd + 1;
        n_busy    = wa + 1 + n_data;
        exp_valid = !((flush_idx >= 0 && flush_idx < n_busy) || flush_done);
        exp_data  = err ? 32'h0 : d;
        bc        = 0;

        IAHB_access = 1'b1;
        IAHB_addr   = a;
        fetch_flush = 1'b0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;

        for (int k = 0; k <= wa; k++) begin
            @(negedge cpu_clk);
            check("addr_htrans", 32'(bus.HTRANS), 32'h2);
            check("addr_haddr", bus.HADDR, a & 32'hFFFF_FFFC);
            check("addr_busy", 32'(IAHB_busy), 32'h1);
            check("addr_valid", 32'(IAHB_read_data_valid), 32'h0);
            IAHB_access = 1'b0;
            bus.HREADY  = (k == wa);
            bus.HRESP   = 1'b0;
            bus.HRDATA  = $urandom;
            fetch_flush = (bc == flush_idx);
            bc++;
        end

        for (int k = 0; k < n_data; k++) begin
            @(negedge cpu_clk);
            check("data_htrans", 32'(bus.HTRANS), 32'h0);
            check("data_valid", 32'(IAHB_read_data_valid), 32'h0);
            if (!err) begin
                bus.HREADY = (k == wd);
                bus.HRESP  = 1'b0;
                bus.HRDATA = (k == wd) ? d : $urandom;
            end else begin
                bus.HREADY = (k == n_data - 1);
                bus.HRESP  = (k >= wd);
                bus.HRDATA = $urandom;
            end
            fetch_flush = (bc == flush_idx);
            bc++;
        end

        @(posedge cpu_clk);
        #1;
        fetch_flush = flush_done;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;

        @(negedge cpu_clk);
        check("done_valid", 32'(IAHB_read_data_valid), 32'(exp_valid));
        if (exp_valid) check("done_data", IAHB_read_data, exp_data);
        check("done_htrans", 32'(bus.HTRANS), 32'h0);
`ifdef IAHB_ERR_REPORT_EN
        check("done_bus_error", 32'(IAHB_bus_error), 32'(err && exp_valid));
        if (err) check("done_err_addr", IAHB_err_addr, a);
`endif
        fetch_flush = 1'b0;
        IAHB_access = hold_next;
        IAHB_addr   = next_a;

        @(negedge cpu_clk);
        check("idle_valid", 32'(IAHB_read_data_valid), 32'h0);
        check("idle_busy", 32'(IAHB_busy), 32'h0);
        check("idle_htrans", 32'(bus.HTRANS), 32'h0);
    endtask

    // Directed steps followed by randomized fetches
    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        cpu_rstn    = 1'b0;
        IAHB_access = 1'b0;
        IAHB_addr   = '0;
        fetch_flush = 1'b0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;
        bus.HRDATA  = '0;

        repeat (2) @(negedge cpu_clk);
        check("rst_htrans", 32'(bus.HTRANS), 32'h0);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("rst_data", IAHB_read_data, 32'h0);
        check("rst_valid", 32'(IAHB_read_data_valid), 32'h0);
        check("rst_busy", 32'(IAHB_busy), 32'h0);
        check("hwrite", 32'(bus.HWRITE), 32'h0);
        check("hsize", 32'(bus.HSIZE), 32'h2);
        check("hburst", 32'(bus.HBURST), 32'h0);
        check("hprot", 32'(bus.HPROT), 32'h2);
`ifdef IAHB_ERR_REPORT_EN
        check("rst_bus_error", 32'(IAHB_bus_error), 32'h0);
        check("rst_err_addr", IAHB_err_addr, 32'h0);
`endif
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        $display("[TB] zero-wait fetch");
        run_txn(32'h0000_4000, 32'h0000_0013, 0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);
        $display("[TB] wait states in address and data phase");
        run_txn(32'h0000_4000, 32'h1234_5678, 3, 2, 1'b0, -1, 1'b0, 1'b0, 32'h0);
        $display("[TB] error response");
        run_txn(32'h0000_5000, 32'hDEAD_BEEF, 0, 0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
        $display("[TB] flush during data phase, then normal fetch");
        run_txn(32'h0000_4000, 32'hAAAA_5555, 0, 1, 1'b0, 1, 1'b0, 1'b0, 32'h0);
        run_txn(32'h0000_6000, 32'h0000_0093, 0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);
        $display("[TB] request held across completion");
        run_txn(32'h0000_4000, 32'h0000_0013, 0, 0, 1'b0, -1, 1'b0, 1'b1, 32'h0000_4004);
        run_txn(32'h0000_4004, 32'h0040_0113, 0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);
        $display("[TB] flush in DONE and unaligned address");
        run_txn(32'h0000_7003, 32'h5A5A_A5A5, 1, 0, 1'b0, -1, 1'b1, 1'b0, 32'h0);

        $display("[TB] flush in IDLE blocks acceptance");
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_8000;
        fetch_flush = 1'b1;
        @(negedge cpu_clk);
        check("flush_idle_busy", 32'(IAHB_busy), 32'h0);
        check("flush_idle_htrans", 32'(bus.HTRANS), 32'h0);
        fetch_flush = 1'b0;
        run_txn(32'h0000_8000, 32'h0000_0073, 0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);

        $display("[TB] reset during data phase");
        IAHB_access = 1'b1;
        IAHB_addr   = 32'h0000_9000;
        @(negedge cpu_clk);
        IAHB_access = 1'b0;
        @(negedge cpu_clk);
        bus.HREADY = 1'b0;
        @(posedge cpu_clk);
        #2;
        cpu_rstn = 1'b0;
        #1;
        check("rst_mid_htrans", 32'(bus.HTRANS), 32'h0);
        check("rst_mid_busy", 32'(IAHB_busy), 32'h0);
        check("rst_mid_valid", 32'(IAHB_read_data_valid), 32'h0);
        @(negedge cpu_clk);
        cpu_rstn   = 1'b1;
        bus.HREADY = 1'b1;
        @(negedge cpu_clk);
        check("post_rst_busy", 32'(IAHB_busy), 32'h0);
        check("post_rst_valid", 32'(IAHB_read_data_valid), 32'h0);
        run_txn(32'h0000_A000, 32'h0000_0513, 0, 0, 1'b0, -1, 1'b0, 1'b0, 32'h0);

        $display("[TB] randomized fetches");
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rd = $urandom;
            run_txn(ra, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
                    ($urandom_range(0, 7) == 0), 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
